// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC write-back scoreboard.
// Opcode/register widths, pipe entry type and the default write mask.
package wisc_pkg;

    localparam int OPCODE_W = 5;
    localparam int NUM_REGS = 8;
    localparam int REG_W    = $clog2(NUM_REGS);

    localparam logic [2**OPCODE_W-1:0] REGWRITE_MASK_DEF = 32'hFEFA_0F00;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] rd;
    } sb_entry_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// ID-side bundle between decode and the write-back scoreboard.
// The master is the decode stage; the slave is the scoreboard.
interface wb_scoreboard_if
    import wisc_pkg::*;
();

    logic                id_valid;
    logic [OPCODE_W-1:0] id_opcode;
    logic [REG_W-1:0]    id_rd;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic                id_rs_used;
    logic                id_rt_used;
    logic                flush;
    logic                stall;
    logic                issue;
    logic                id_regwrite;
    logic                wb_en;
    logic [REG_W-1:0]    wb_rd;
    logic [NUM_REGS-1:0] busy;

    modport master (
        output id_valid, id_opcode, id_rd, id_rs, id_rt,
        output id_rs_used, id_rt_used, flush,
        input  stall, issue, id_regwrite, wb_en, wb_rd, busy
    );

    modport slave (
        input  id_valid, id_opcode, id_rd, id_rs, id_rt,
        input  id_rs_used, id_rt_used, flush,
        output stall, issue, id_regwrite, wb_en, wb_rd, busy
    );

endinterface

// File: rtl/wb_scoreboard_regwrite_decode.sv
// Opcode to register write-enable lookup.
// One mask bit per opcode replaces a per-opcode comparator bank.
module regwrite_decode
    import wisc_pkg::*;
#(
    parameter int              W    = OPCODE_W,
    parameter logic [2**W-1:0] MASK = REGWRITE_MASK_DEF
) (
    input  logic [W-1:0] opcode_i,
    output logic         regwrite_o
);

    assign regwrite_o = MASK[opcode_i];

endmodule

// File: rtl/wb_scoreboard.sv
// Register-write hazard scoreboard between ID and the back end.
// Tracks in-flight writes, stalls RAW hazards, squashes on flush.
module wb_scoreboard
    import wisc_pkg::*;
#(
    parameter int                     DEPTH         = 4,
    parameter int                     FLUSH_DEPTH   = 2,
    parameter logic [2**OPCODE_W-1:0] REGWRITE_MASK = REGWRITE_MASK_DEF
) (
    input logic             clk,
    input logic             rst_n,
    wb_scoreboard_if.slave  sb
);

    localparam int CW = $clog2(DEPTH + 1);

    sb_entry_t           stage_q [DEPTH];
    sb_entry_t           stage_d [DEPTH];
    logic [CW-1:0]       cnt_q   [NUM_REGS];
    logic [CW-1:0]       cnt_d   [NUM_REGS];
    logic [CW-1:0]       sq      [NUM_REGS];
    logic [NUM_REGS-1:0] ins;
    logic [NUM_REGS-1:0] ret;
    logic [NUM_REGS-1:0] cnt_err;
    logic [NUM_REGS-1:0] busy;
    logic                regwrite;
    logic                hz_rs;
    logic                hz_rt;
    logic                stall;
    logic                issue;

    regwrite_decode #(
        .W    (OPCODE_W),
        .MASK (REGWRITE_MASK)
    ) u_dec (
        .opcode_i   (sb.id_opcode),
        .regwrite_o (regwrite)
    );

    // Retirement this cycle, one-hot by destination register.
    always_comb begin
        ret = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            ret[r] = stage_q[DEPTH-1].v &&
                     (stage_q[DEPTH-1].rd == REG_W'(r));
        end
    end

    // RAW check; a same-cycle retire already satisfies the read.
    always_comb begin
        hz_rs = sb.id_rs_used &&
                (cnt_q[sb.id_rs] != CW'(ret[sb.id_rs]));
        hz_rt = sb.id_rt_used &&
                (cnt_q[sb.id_rt] != CW'(ret[sb.id_rt]));
        stall = sb.id_valid && !sb.flush && (hz_rs || hz_rt);
        issue = sb.id_valid && !sb.flush && !stall;
    end

    // Next pipe contents; young stages lose their valid on flush.
    always_comb begin
        stage_d[0].v  = issue && regwrite;
        stage_d[0].rd = sb.id_rd;
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
            if (sb.flush && (k <= FLUSH_DEPTH)) begin
                stage_d[k].v = 1'b0;
            end
        end
    end

    // Per-register pending count: insert minus retire minus squash.
    always_comb begin
        logic [CW+1:0] nx;
        nx      = '0;
        ins     = '0;
        cnt_err = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            ins[r] = stage_d[0].v && (sb.id_rd == REG_W'(r));
            sq[r]  = '0;
            for (int k = 0; k < FLUSH_DEPTH; k++) begin
                if (sb.flush && stage_q[k].v &&
                    (stage_q[k].rd == REG_W'(r))) begin
                    sq[r] = sq[r] + CW'(1);
                end
            end
            nx = {2'b00, cnt_q[r]} + (CW+2)'(ins[r])
               - (CW+2)'(ret[r]) - {2'b00, sq[r]};
            cnt_d[r]   = nx[CW-1:0];
            cnt_err[r] = nx[CW+1] || (nx > (CW+2)'(DEPTH));
        end
    end

    // Pipe and counter state; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    // Debug view of which registers have writes outstanding.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    a_cnt_range: assert property (
        @(posedge clk) disable iff (!rst_n) cnt_err == '0
    );

    assign sb.stall       = stall;
    assign sb.issue       = issue;
    assign sb.id_regwrite = regwrite;
    assign sb.wb_en       = stage_q[DEPTH-1].v;
    assign sb.wb_rd       = stage_q[DEPTH-1].rd;
    assign sb.busy        = busy;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard.
// Each task drives one scenario and checks cycle by cycle.
module tb_wb_scoreboard;
    import wisc_pkg::*;

    localparam logic [31:0] MASK = 32'hFEFA_0F00;
    localparam logic [4:0]  OP_W = 5'b11011;
    localparam logic [4:0]  OP_N = 5'b00000;

    logic clk;
    logic rst_n;
    int   npass = 0;
    int   ntot  = 0;

    wb_scoreboard_if sbif();

    wb_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op,
                         input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic rsu,
                         input logic rtu, input logic fl);
        sbif.id_valid   = v;
        sbif.id_opcode  = op;
        sbif.id_rd      = rd;
        sbif.id_rs      = rs;
        sbif.id_rt      = rt;
        sbif.id_rs_used = rsu;
        sbif.id_rt_used = rtu;
        sbif.flush      = fl;
    endtask

    task automatic idle();
        drive(1'b0, OP_N, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, OP_N, 3'd0, 3'd1, 3'd2, 1'b1, 1'b1, 1'b0);
        repeat (2) tick();
        #1;
        ntot++;
        if (sbif.wb_en !== 1'b0 || sbif.wb_rd !== 3'd0)
            $display("FAIL rst_wb got en=%b rd=%0d want 0/0",
                     sbif.wb_en, sbif.wb_rd);
        else npass++;
        ntot++;
        if (sbif.busy !== 8'h00 || sbif.stall !== 1'b0)
            $display("FAIL rst_busy got busy=%h stall=%b want 00/0",
                     sbif.busy, sbif.stall);
        else npass++;
        idle();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c < 3)
                drive(1'b1, OP_W, 3'(c + 1), 3'd0, 3'd0,
                      1'b0, 1'b0, 1'b0);
            else
                idle();
        end
        #1;
        ntot++;
        if (sbif.wb_en !== 1'b1 || sbif.wb_rd !== 3'd1 ||
            sbif.busy !== 8'h0E)
            $display("FAIL rst_pre got en=%b rd=%0d busy=%h want 1/1/0e",
                     sbif.wb_en, sbif.wb_rd, sbif.busy);
        else npass++;
        rst_n = 1'b0;
        #1;
        ntot++;
        if (sbif.wb_en !== 1'b0 || sbif.busy !== 8'h00)
            $display("FAIL rst_mid got en=%b busy=%h want 0/00",
                     sbif.wb_en, sbif.busy);
        else npass++;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            ntot++;
            if (sbif.wb_en !== 1'b0)
                $display("FAIL rst_stale c%0d got en=%b want 0",
                         c, sbif.wb_en);
            else npass++;
        end
    endtask

    task automatic test_decode();
        idle();
        for (int op = 0; op < 32; op++) begin
            sbif.id_opcode = 5'(op);
            #1;
            ntot++;
            if (sbif.id_regwrite !== MASK[op])
                $display("FAIL dec op%0d got %b want %b",
                         op, sbif.id_regwrite, MASK[op]);
            else npass++;
        end
        tick();
        drive(1'b1, OP_W, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
        ntot++;
        if (sbif.issue !== 1'b1 || sbif.id_regwrite !== 1'b1)
            $display("FAIL add_issue got iss=%b we=%b want 1/1",
                     sbif.issue, sbif.id_regwrite);
        else npass++;
        for (int c = 1; c <= 5; c++) begin
            tick();
            idle();
            #1;
            ntot++;
            if (sbif.wb_en !== (c == 4) ||
                (c == 4 && sbif.wb_rd !== 3'd3))
                $display("FAIL add_wb c%0d got en=%b rd=%0d want %b/3",
                         c, sbif.wb_en, sbif.wb_rd, c == 4);
            else npass++;
        end
        tick();
        drive(1'b1, OP_N, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            idle();
            #1;
            ntot++;
            if (sbif.wb_en !== 1'b0 || sbif.busy !== 8'h00)
                $display("FAIL nowr c%0d got en=%b busy=%h want 0/00",
                         c, sbif.wb_en, sbif.busy);
            else npass++;
        end
    endtask

    task automatic test_raw();
        tick();
        drive(1'b1, OP_W, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            drive(1'b1, OP_N, 3'd0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0);
            #1;
            ntot++;
            if (sbif.stall !== (c < 4) || sbif.issue !== (c == 4))
                $display("FAIL raw c%0d got st=%b iss=%b want %b/%b",
                         c, sbif.stall, sbif.issue, c < 4, c == 4);
            else npass++;
        end
        ntot++;
        if (sbif.wb_en !== 1'b1 || sbif.wb_rd !== 3'd2)
            $display("FAIL raw_wb got en=%b rd=%0d want 1/2",
                     sbif.wb_en, sbif.wb_rd);
        else npass++;
        drain();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 6; c++) begin
            tick();
            if (c < 2)
                drive(1'b1, OP_W, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
            else if (c <= 5)
                drive(1'b1, OP_N, 3'd0, 3'd0, 3'd5, 1'b0, 1'b1, 1'b0);
            else
                idle();
            #1;
            if (c >= 2 && c <= 5) begin
                ntot++;
                if (sbif.stall !== (c < 5) || sbif.issue !== (c == 5))
                    $display("FAIL waw_rd c%0d got st=%b iss=%b want %b/%b",
                             c, sbif.stall, sbif.issue, c < 5, c == 5);
                else npass++;
            end
            if (c >= 1) begin
                ntot++;
                if (sbif.busy[5] !== (c <= 5))
                    $display("FAIL waw_busy c%0d got %b want %b",
                             c, sbif.busy[5], c <= 5);
                else npass++;
            end
            if (c == 2) begin
                ntot++;
                if (dut.cnt_q[5] !== 3'd2)
                    $display("FAIL waw_cnt got %0d want 2", dut.cnt_q[5]);
                else npass++;
            end
            if (c == 4 || c == 5) begin
                ntot++;
                if (sbif.wb_en !== 1'b1 || sbif.wb_rd !== 3'd5)
                    $display("FAIL waw_wb c%0d got en=%b rd=%0d want 1/5",
                             c, sbif.wb_en, sbif.wb_rd);
                else npass++;
            end
        end
        drain();
    endtask

    task automatic test_flush();
        for (int c = 0; c <= 8; c++) begin
            tick();
            if (c == 0)
                drive(1'b1, OP_W, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
            else if (c == 1)
                drive(1'b1, OP_W, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
            else if (c == 2)
                drive(1'b1, OP_W, 3'd6, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
            else if (c == 3)
                drive(1'b1, OP_W, 3'd7, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
            else
                idle();
            #1;
            if (c == 3) begin
                ntot++;
                if (sbif.issue !== 1'b0 || sbif.busy !== 8'h52)
                    $display("FAIL fl_cyc got iss=%b busy=%h want 0/52",
                             sbif.issue, sbif.busy);
                else npass++;
            end
            if (c == 4) begin
                ntot++;
                if (sbif.wb_en !== 1'b1 || sbif.wb_rd !== 3'd1 ||
                    sbif.busy !== 8'h02)
                    $display("FAIL fl_keep got en=%b rd=%0d busy=%h want 1/1/02",
                             sbif.wb_en, sbif.wb_rd, sbif.busy);
                else npass++;
            end
            if (c >= 5) begin
                ntot++;
                if (sbif.wb_en !== 1'b0 || sbif.busy !== 8'h00)
                    $display("FAIL fl_sq c%0d got en=%b busy=%h want 0/00",
                             c, sbif.wb_en, sbif.busy);
                else npass++;
            end
        end
        drain();
    endtask

    task automatic test_flush_stall();
        tick();
        drive(1'b1, OP_W, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, OP_N, 3'd0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0);
        #1;
        ntot++;
        if (sbif.stall !== 1'b1 || sbif.issue !== 1'b0)
            $display("FAIL fs_pre got st=%b iss=%b want 1/0",
                     sbif.stall, sbif.issue);
        else npass++;
        tick();
        sbif.flush = 1'b1;
        #1;
        ntot++;
        if (sbif.stall !== 1'b0 || sbif.issue !== 1'b0)
            $display("FAIL fs_fl got st=%b iss=%b want 0/0",
                     sbif.stall, sbif.issue);
        else npass++;
        tick();
        sbif.flush = 1'b0;
        #1;
        ntot++;
        if (sbif.stall !== 1'b0 || sbif.issue !== 1'b1 ||
            sbif.busy !== 8'h00)
            $display("FAIL fs_next got st=%b iss=%b busy=%h want 0/1/00",
                     sbif.stall, sbif.issue, sbif.busy);
        else npass++;
        idle();
        for (int c = 0; c < 5; c++) begin
            tick();
            ntot++;
            if (sbif.wb_en !== 1'b0)
                $display("FAIL fs_wb c%0d got en=%b want 0", c, sbif.wb_en);
            else npass++;
        end
    endtask

    task automatic test_ins_ret();
        for (int c = 0; c <= 9; c++) begin
            tick();
            if (c == 0 || c == 4)
                drive(1'b1, OP_W, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
            else
                idle();
            #1;
            if (c >= 5) begin
                ntot++;
                if (sbif.busy[2] !== (c <= 8))
                    $display("FAIL insret_busy c%0d got %b want %b",
                             c, sbif.busy[2], c <= 8);
                else npass++;
            end
            if (c == 8) begin
                ntot++;
                if (sbif.wb_en !== 1'b1 || sbif.wb_rd !== 3'd2)
                    $display("FAIL insret_wb got en=%b rd=%0d want 1/2",
                             sbif.wb_en, sbif.wb_rd);
                else npass++;
            end
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_decode();
        test_raw();
        test_back_to_back();
        test_flush();
        test_flush_stall();
        test_ins_ret();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
